// File: rtl/alu_multicycle.sv
// Multicycle ALU responder behind the bgn/rdy handshake.
// Single-cycle ops finish in EXEC. MUL/DIV/MOD run WIDTH shift/subtract steps in ITER.
// Results, flags and rdy are held in DONE until bgn is withdrawn.
module alu_multicycle #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bgn,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] acc1,
  output logic [WIDTH-1:0] acc2,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             rdy
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_LSR = 5'b00011;
  localparam logic [4:0] OP_LSL = 5'b00100;
  localparam logic [4:0] OP_RSR = 5'b00101;
  localparam logic [4:0] OP_RSL = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b00111;
  localparam logic [4:0] OP_DIV = 5'b01000;
  localparam logic [4:0] OP_MOD = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_XOR = 5'b01100;
  localparam logic [4:0] OP_NOT = 5'b01101;
  localparam logic [4:0] OP_CMP = 5'b01110;
  localparam logic [4:0] OP_TST = 5'b01111;
  localparam logic [4:0] OP_INC = 5'b10000;
  localparam logic [4:0] OP_DEC = 5'b10001;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, a_nx;
  logic [WIDTH-1:0] b_r, b_nx;
  logic [4:0]       op_r, op_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             primed, primed_nx;
  logic [WIDTH-1:0] wk_hi, hi_nx;
  logic [WIDTH-1:0] wk_lo, lo_nx;
  logic [WIDTH-1:0] acc1_nx, acc2_nx;
  logic             zero_nx, negative_nx, carry_nx, overflow_nx, rdy_nx;

  // Immediate-select bit is resolved before this block.
  logic unused_imm;
  assign unused_imm = opcode[0];

  // Operations that take the iterative path (divide by zero does not).
  logic req_iter;
  assign req_iter = (opcode[5:1] == OP_MUL) ||
                    (((opcode[5:1] == OP_DIV) || (opcode[5:1] == OP_MOD)) && (B != '0));

  // Single-cycle datapath on the latched operands.
  logic [CW-1:0]    sh;
  logic             sh_nz;
  logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w, lsl_w, lsr_w;
  logic [WIDTH-1:0] rr_res, rl_res;
  logic             ex_write, ex_flags, ex_c, ex_v;
  logic [WIDTH-1:0] ex_res, ex_acc2;

  // Compute the EXEC result, acc2 value and carry/overflow for every single-cycle op.
  always_comb begin
    sh       = b_r[CW-1:0];
    sh_nz    = (sh != '0);
    add_w    = {1'b0, a_r} + {1'b0, b_r};
    sub_w    = {1'b0, a_r} - {1'b0, b_r};
    inc_w    = {1'b0, a_r} + (WIDTH+1)'(1);
    dec_w    = {1'b0, a_r} - (WIDTH+1)'(1);
    lsl_w    = {1'b0, a_r} << sh;
    lsr_w    = {a_r, 1'b0} >> sh;
    rr_res   = WIDTH'({a_r, a_r} >> sh);
    rl_res   = WIDTH'(({a_r, a_r} << sh) >> WIDTH);
    ex_write = 1'b0;
    ex_flags = 1'b0;
    ex_res   = '0;
    ex_acc2  = '0;
    ex_c     = 1'b0;
    ex_v     = 1'b0;
    case (op_r)
      OP_ADD: begin
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = add_w[WIDTH-1:0];
        ex_c     = add_w[WIDTH];
        ex_v     = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_w[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        ex_write = (op_r == OP_SUB); ex_flags = 1'b1;
        ex_res   = sub_w[WIDTH-1:0];
        ex_c     = sub_w[WIDTH];
        ex_v     = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sub_w[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_LSR: begin
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = lsr_w[WIDTH:1];
        ex_c     = lsr_w[0];
      end
      OP_LSL: begin
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = lsl_w[WIDTH-1:0];
        ex_c     = lsl_w[WIDTH];
      end
      OP_RSR: begin
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = rr_res;
        ex_c     = sh_nz & rr_res[WIDTH-1];
      end
      OP_RSL: begin
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = rl_res;
        ex_c     = sh_nz & rl_res[0];
      end
      OP_DIV, OP_MOD: begin
        // Only reached with B == 0.
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = '1;
        ex_acc2  = a_r;
        ex_v     = 1'b1;
      end
      OP_AND, OP_TST: begin
        ex_write = (op_r == OP_AND); ex_flags = 1'b1;
        ex_res   = a_r & b_r;
      end
      OP_OR: begin
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = a_r | b_r;
      end
      OP_XOR: begin
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = a_r ^ b_r;
      end
      OP_NOT: begin
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = ~a_r;
      end
      OP_INC: begin
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = inc_w[WIDTH-1:0];
        ex_c     = inc_w[WIDTH];
        ex_v     = ~a_r[WIDTH-1] & inc_w[WIDTH-1];
      end
      OP_DEC: begin
        ex_write = 1'b1; ex_flags = 1'b1;
        ex_res   = dec_w[WIDTH-1:0];
        ex_c     = dec_w[WIDTH];
        ex_v     = a_r[WIDTH-1] & ~dec_w[WIDTH-1];
      end
      default: begin
        ex_write = 1'b0;
        ex_flags = 1'b0;
      end
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide on {wk_hi, wk_lo}.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] it_hi, it_lo;

  always_comb begin
    mul_sum   = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, b_r} : '0);
    div_shift = {wk_hi, wk_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_r});
    div_diff  = WIDTH'(div_shift - {1'b0, b_r});
    if (op_r == OP_MUL) begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], wk_lo[WIDTH-1:1]};
    end else begin
      it_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      it_lo = {wk_lo[WIDTH-2:0], div_ge};
    end
  end

  // Next-state and next-register logic for the handshake FSM.
  always_comb begin
    state_nx    = state;
    a_nx        = a_r;
    b_nx        = b_r;
    op_nx       = op_r;
    cnt_nx      = cnt;
    primed_nx   = primed;
    hi_nx       = wk_hi;
    lo_nx       = wk_lo;
    acc1_nx     = acc1;
    acc2_nx     = acc2;
    zero_nx     = zero;
    negative_nx = negative;
    carry_nx    = carry;
    overflow_nx = overflow;
    rdy_nx      = rdy;
    case (state)
      IDLE: begin
        rdy_nx = 1'b0;
        if (bgn) begin
          a_nx      = A;
          b_nx      = B;
          op_nx     = opcode[5:1];
          cnt_nx    = '0;
          primed_nx = 1'b0;
          state_nx  = req_iter ? ITER : EXEC;
        end
      end
      EXEC: begin
        if (ex_write) begin
          acc1_nx = ex_res;
          acc2_nx = ex_acc2;
        end
        if (ex_flags) begin
          zero_nx     = (ex_res == '0);
          negative_nx = ex_res[WIDTH-1];
          carry_nx    = ex_c;
          overflow_nx = ex_v;
        end
        rdy_nx   = 1'b1;
        state_nx = DONE;
      end
      ITER: begin
        if (!primed) begin
          // First cycle loads the working pair from the latched operands.
          hi_nx     = '0;
          lo_nx     = a_r;
          primed_nx = 1'b1;
        end else begin
          hi_nx  = it_hi;
          lo_nx  = it_lo;
          cnt_nx = cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            cnt_nx      = '0;
            primed_nx   = 1'b0;
            carry_nx    = 1'b0;
            rdy_nx      = 1'b1;
            state_nx    = DONE;
            case (op_r)
              OP_MUL: begin
                acc1_nx     = it_lo;
                acc2_nx     = it_hi;
                zero_nx     = ({it_hi, it_lo} == '0);
                negative_nx = it_lo[WIDTH-1];
                overflow_nx = (it_hi != '0);
              end
              OP_DIV: begin
                acc1_nx     = it_lo;
                acc2_nx     = it_hi;
                zero_nx     = (it_lo == '0);
                negative_nx = it_lo[WIDTH-1];
                overflow_nx = 1'b0;
              end
              default: begin
                acc1_nx     = it_hi;
                acc2_nx     = '0;
                zero_nx     = (it_hi == '0);
                negative_nx = it_hi[WIDTH-1];
                overflow_nx = 1'b0;
              end
            endcase
          end
        end
      end
      DONE: begin
        if (!bgn) begin
          rdy_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= '0;
      cnt      <= '0;
      primed   <= 1'b0;
      wk_hi    <= '0;
      wk_lo    <= '0;
      acc1     <= '0;
      acc2     <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      rdy      <= 1'b0;
    end else begin
      state    <= state_nx;
      a_r      <= a_nx;
      b_r      <= b_nx;
      op_r     <= op_nx;
      cnt      <= cnt_nx;
      primed   <= primed_nx;
      wk_hi    <= hi_nx;
      wk_lo    <= lo_nx;
      acc1     <= acc1_nx;
      acc2     <= acc2_nx;
      zero     <= zero_nx;
      negative <= negative_nx;
      carry    <= carry_nx;
      overflow <= overflow_nx;
      rdy      <= rdy_nx;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle.
module tb_alu_multicycle;

  logic        clk;
  logic        rst;
  logic        bgn;
  logic [5:0]  opcode;
  logic [15:0] A, B;
  logic [15:0] acc1, acc2;
  logic        zero, negative, carry, overflow, rdy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_multicycle #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bgn(bgn), .opcode(opcode), .A(A), .B(B),
    .acc1(acc1), .acc2(acc2), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow), .rdy(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  // Present a request so it is accepted at the next rising edge (edge N), then scramble inputs.
  task automatic start_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    opcode = {op, 1'b1};
    A      = a;
    B      = b;
    bgn    = 1'b1;
    @(posedge clk);
    #1;
    A      = 16'hDEAD;
    B      = 16'h0000;
    opcode = 6'h3F;
  endtask

  // Edges after acceptance until rdy is first seen; -1 if it never comes.
  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    bgn = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bgn = 1'b0; opcode = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (acc1 !== 16'h0) begin n_bad++; $display("FAIL reset_acc1 got=%h exp=0000", acc1); end
    n_cmp++; if (acc2 !== 16'h0) begin n_bad++; $display("FAIL reset_acc2 got=%h exp=0000", acc2); end
    n_cmp++; if ({zero, negative, carry, overflow} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got=%b exp=0000", {zero, negative, carry, overflow}); end
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    start_op(5'b00001, 16'h7FFF, 16'h0001);
    wait_rdy(lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_latency got=%0d exp=1", lat); end
    n_cmp++; if (acc1 !== 16'h8000) begin n_bad++; $display("FAIL add_acc1 got=%h exp=8000", acc1); end
    n_cmp++; if (acc2 !== 16'h0000) begin n_bad++; $display("FAIL add_acc2 got=%h exp=0000", acc2); end
    n_cmp++; if ({zero, negative, carry, overflow} !== 4'b0101) begin n_bad++; $display("FAIL add_flags got=%b exp=0101", {zero, negative, carry, overflow}); end
    finish_op();
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL add_rdy_drop got=%b exp=0", rdy); end
  endtask

  task automatic test_mul();
    int lat;
    start_op(5'b00111, 16'h1234, 16'h0100);
    wait_rdy(lat);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL mul_latency got=%0d exp=17", lat); end
    n_cmp++; if (acc1 !== 16'h3400) begin n_bad++; $display("FAIL mul_acc1 got=%h exp=3400", acc1); end
    n_cmp++; if (acc2 !== 16'h0012) begin n_bad++; $display("FAIL mul_acc2 got=%h exp=0012", acc2); end
    n_cmp++; if ({zero, negative, carry, overflow} !== 4'b0001) begin n_bad++; $display("FAIL mul_flags got=%b exp=0001", {zero, negative, carry, overflow}); end
    finish_op();
  endtask

  task automatic test_div();
    int lat;
    start_op(5'b01000, 16'd100, 16'd7);
    wait_rdy(lat);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL div_latency got=%0d exp=17", lat); end
    n_cmp++; if (acc1 !== 16'd14) begin n_bad++; $display("FAIL div_acc1 got=%h exp=000e", acc1); end
    n_cmp++; if (acc2 !== 16'd2) begin n_bad++; $display("FAIL div_acc2 got=%h exp=0002", acc2); end
    n_cmp++; if ({zero, negative, carry, overflow} !== 4'b0000) begin n_bad++; $display("FAIL div_flags got=%b exp=0000", {zero, negative, carry, overflow}); end
    finish_op();
    start_op(5'b01001, 16'd100, 16'd7);
    wait_rdy(lat);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL mod_latency got=%0d exp=17", lat); end
    n_cmp++; if (acc1 !== 16'd2) begin n_bad++; $display("FAIL mod_acc1 got=%h exp=0002", acc1); end
    n_cmp++; if (acc2 !== 16'd0) begin n_bad++; $display("FAIL mod_acc2 got=%h exp=0000", acc2); end
    finish_op();
    start_op(5'b01000, 16'd100, 16'd0);
    wait_rdy(lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL divz_latency got=%0d exp=1", lat); end
    n_cmp++; if (acc1 !== 16'hFFFF) begin n_bad++; $display("FAIL divz_acc1 got=%h exp=ffff", acc1); end
    n_cmp++; if (acc2 !== 16'h0064) begin n_bad++; $display("FAIL divz_acc2 got=%h exp=0064", acc2); end
    n_cmp++; if ({zero, negative, carry, overflow} !== 4'b0101) begin n_bad++; $display("FAIL divz_flags got=%b exp=0101", {zero, negative, carry, overflow}); end
    finish_op();
  endtask

  task automatic test_cmp_sub();
    int lat;
    start_op(5'b00001, 16'h0050, 16'h0005);
    wait_rdy(lat);
    finish_op();
    n_cmp++; if (acc1 !== 16'h0055) begin n_bad++; $display("FAIL load_acc1 got=%h exp=0055", acc1); end
    start_op(5'b01110, 16'd5, 16'd5);
    wait_rdy(lat);
    n_cmp++; if (acc1 !== 16'h0055) begin n_bad++; $display("FAIL cmp_acc1 got=%h exp=0055", acc1); end
    n_cmp++; if ({zero, negative, carry, overflow} !== 4'b1000) begin n_bad++; $display("FAIL cmp_flags got=%b exp=1000", {zero, negative, carry, overflow}); end
    finish_op();
    start_op(5'b00010, 16'd3, 16'd5);
    wait_rdy(lat);
    n_cmp++; if (acc1 !== 16'hFFFE) begin n_bad++; $display("FAIL sub_acc1 got=%h exp=fffe", acc1); end
    n_cmp++; if ({zero, negative, carry, overflow} !== 4'b0110) begin n_bad++; $display("FAIL sub_flags got=%b exp=0110", {zero, negative, carry, overflow}); end
    finish_op();
    start_op(5'b10001, 16'h8000, 16'h0000);
    wait_rdy(lat);
    n_cmp++; if (acc1 !== 16'h7FFF) begin n_bad++; $display("FAIL dec_acc1 got=%h exp=7fff", acc1); end
    n_cmp++; if ({zero, negative, carry, overflow} !== 4'b0001) begin n_bad++; $display("FAIL dec_flags got=%b exp=0001", {zero, negative, carry, overflow}); end
    finish_op();
  endtask

  task automatic test_logic();
    int lat;
    start_op(5'b01101, 16'hFFFF, 16'h1234);
    wait_rdy(lat);
    n_cmp++; if ({acc1, zero, negative} !== {16'h0000, 2'b10}) begin n_bad++; $display("FAIL not_result got=%h/%b%b exp=0000/10", acc1, zero, negative); end
    finish_op();
    start_op(5'b01100, 16'hFF00, 16'h0FF0);
    wait_rdy(lat);
    n_cmp++; if ({acc1, zero, negative} !== {16'hF0F0, 2'b01}) begin n_bad++; $display("FAIL xor_result got=%h/%b%b exp=f0f0/01", acc1, zero, negative); end
    finish_op();
    start_op(5'b01111, 16'h00F0, 16'h0F0F);
    wait_rdy(lat);
    n_cmp++; if ({acc1, zero, negative} !== {16'hF0F0, 2'b10}) begin n_bad++; $display("FAIL tst_result got=%h/%b%b exp=f0f0/10", acc1, zero, negative); end
    finish_op();
  endtask

  task automatic test_shift();
    int lat;
    start_op(5'b00100, 16'h8001, 16'd1);
    wait_rdy(lat);
    n_cmp++; if ({acc1, carry} !== {16'h0002, 1'b1}) begin n_bad++; $display("FAIL lsl got=%h c=%b exp=0002 c=1", acc1, carry); end
    finish_op();
    start_op(5'b00011, 16'h0003, 16'd1);
    wait_rdy(lat);
    n_cmp++; if ({acc1, carry} !== {16'h0001, 1'b1}) begin n_bad++; $display("FAIL lsr got=%h c=%b exp=0001 c=1", acc1, carry); end
    finish_op();
    start_op(5'b00101, 16'h0008, 16'd4);
    wait_rdy(lat);
    n_cmp++; if ({acc1, negative, carry} !== {16'h8000, 2'b11}) begin n_bad++; $display("FAIL rsr got=%h nc=%b%b exp=8000 nc=11", acc1, negative, carry); end
    finish_op();
    start_op(5'b00011, 16'h1234, 16'h0010);
    wait_rdy(lat);
    n_cmp++; if ({acc1, carry} !== {16'h1234, 1'b0}) begin n_bad++; $display("FAIL shift0 got=%h c=%b exp=1234 c=0", acc1, carry); end
    finish_op();
    start_op(5'b00110, 16'h8000, 16'd1);
    wait_rdy(lat);
    n_cmp++; if ({acc1, carry} !== {16'h0001, 1'b1}) begin n_bad++; $display("FAIL rsl got=%h c=%b exp=0001 c=1", acc1, carry); end
    finish_op();
  endtask

  task automatic test_undefined();
    int lat;
    start_op(5'b10010, 16'h5555, 16'h1111);
    wait_rdy(lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL undef_latency got=%0d exp=1", lat); end
    n_cmp++; if ({acc1, acc2, zero, negative, carry, overflow} !== {16'h0001, 16'h0000, 4'b0010}) begin
      n_bad++; $display("FAIL undef_hold got=%h %h %b exp=0001 0000 0010", acc1, acc2, {zero, negative, carry, overflow}); end
    finish_op();
  endtask

  task automatic test_hold_bgn();
    int lat;
    int bad_cycles;
    start_op(5'b00001, 16'h1111, 16'h2222);
    wait_rdy(lat);
    bad_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      A = 16'(i * 3); B = 16'(i); opcode = {5'b00001, 1'b0};
      @(posedge clk);
      #1;
      if (rdy !== 1'b1 || acc1 !== 16'h3333) bad_cycles++;
    end
    n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL hold_bgn bad_cycles=%0d exp=0", bad_cycles); end
    finish_op();
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL hold_rdy_drop got=%b exp=0", rdy); end
  endtask

  task automatic test_back_to_back_drop();
    int lat;
    start_op(5'b00111, 16'd3, 16'd5);
    @(negedge clk);
    bgn = 1'b0;
    wait_rdy(lat);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL drop_latency got=%0d exp=17", lat); end
    n_cmp++; if ({acc1, acc2, overflow} !== {16'd15, 16'd0, 1'b0}) begin n_bad++; $display("FAIL drop_result got=%h %h v=%b exp=000f 0000 v=0", acc1, acc2, overflow); end
    @(posedge clk);
    #1;
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL drop_rdy_pulse got=%b exp=0", rdy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int rdy_seen;
    start_op(5'b00111, 16'h1234, 16'h0100);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bgn = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if ({acc1, acc2, zero, negative, carry, overflow, rdy} !== 37'h0) begin
      n_bad++; $display("FAIL midreset_outputs got=%h %h %b rdy=%b exp=all zero", acc1, acc2, {zero, negative, carry, overflow}, rdy); end
    @(negedge clk);
    rst = 1'b0;
    rdy_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rdy !== 1'b0) rdy_seen++;
    end
    n_cmp++; if (rdy_seen !== 0) begin n_bad++; $display("FAIL midreset_no_rdy got=%0d exp=0", rdy_seen); end
    start_op(5'b10000, 16'hFFFF, 16'h0000);
    wait_rdy(lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL inc_latency got=%0d exp=1", lat); end
    n_cmp++; if ({acc1, zero, negative, carry, overflow} !== {16'h0000, 4'b1010}) begin
      n_bad++; $display("FAIL inc_result got=%h %b exp=0000 1010", acc1, {zero, negative, carry, overflow}); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_cmp_sub();
    test_logic();
    test_shift();
    test_undefined();
    test_hold_bgn();
    test_back_to_back_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
